directory_req_sched: RTL and testbench

Request scheduler in front of the directory bank. It buffers L2 demand requests and L2 prefetch requests in two separate queues and presents one request at a time to the bank's request port. Demand requests win arbitration by default, with a starvation guard for prefetches. The prefetch queue never back-pressures in normal operation: when it is full, the oldest entry is dropped.

---
 rtl/directory_req_sched.sv | 175 +++++++++++++++++
 tb/tb_directory_req_sched.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/directory_req_sched.sv
// Purpose: shared request payload type for the L2-to-directory request channels.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package directory_req_sched_pkg;
   typedef struct packed {
      logic [4:0]  nid;
      logic [5:0]  l2id;
      logic [2:0]  cmd;
      logic [37:0] paddr;
   } I_l2todr_req_type;
endpackage

// Purpose: queue L2 demand and prefetch requests, arbitrate one at a time into the directory bank.
// Latency: 1 cycle from an accepted push into an empty queue to drbank_req_valid (no bypass).
// Backpressure: demand retries when full; prefetch drops its oldest entry when full, retrying only while its full head is held.
module directory_req_sched
   import directory_req_sched_pkg::*;
#(
   parameter int REQ_DEPTH = 8,
   parameter int PF_DEPTH  = 8,
   parameter int PF_STARVE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             l2todr_req_valid,
   output logic             l2todr_req_retry,
   input  I_l2todr_req_type l2todr_req,
   input  logic             l2todr_pfreq_valid,
   output logic             l2todr_pfreq_retry,
   input  I_l2todr_req_type l2todr_pfreq,
   output logic             drbank_req_valid,
   input  logic             drbank_req_retry,
   output I_l2todr_req_type drbank_req,
   output logic             drbank_req_is_pf,
   output logic [15:0]      pf_drop_cnt
);

   localparam int DPW = $clog2(REQ_DEPTH);
   localparam int DCW = DPW + 1;
   localparam int PPW = $clog2(PF_DEPTH);
   localparam int PCW = PPW + 1;

   I_l2todr_req_type d_mem [REQ_DEPTH];
   I_l2todr_req_type p_mem [PF_DEPTH];
   logic [DPW-1:0]   d_wr_ptr, d_rd_ptr;
   logic [DCW-1:0]   d_cnt;
   logic [PPW-1:0]   p_wr_ptr, p_rd_ptr;
   logic [PCW-1:0]   p_cnt;
   logic             hold, hold_pf;
   logic [3:0]       starve_cnt;
   logic [15:0]      drop_cnt;

   logic d_full, d_empty, p_full, p_empty;
   logic d_push, d_pop, p_push, p_pop, p_drop, p_inc;
   logic sel_vld, sel_pf, xfer;

   // Queue status and handshake qualifiers, all from registered state
   assign d_full   = (d_cnt == DCW'(REQ_DEPTH));
   assign d_empty  = (d_cnt == '0);
   assign p_full   = (p_cnt == PCW'(PF_DEPTH));
   assign p_empty  = (p_cnt == '0);

   assign l2todr_req_retry   = d_full;
   // A held prefetch head must never be dropped, so only then does the prefetch port push back
   assign l2todr_pfreq_retry = p_full & hold & hold_pf;

   assign d_push = l2todr_req_valid & ~d_full;
   assign p_push = l2todr_pfreq_valid & ~l2todr_pfreq_retry;
   assign xfer   = sel_vld & ~drbank_req_retry;
   assign d_pop  = xfer & ~sel_pf;
   assign p_pop  = xfer & sel_pf;
   assign p_drop = p_push & p_full & ~p_pop;
   assign p_inc  = p_push & ~p_drop;

   assign drbank_req_valid = sel_vld;
   assign drbank_req_is_pf = sel_pf;
   assign pf_drop_cnt      = drop_cnt;

   // Select the source queue: frozen while held, else starvation guard, demand, prefetch
   always_comb begin
      sel_vld    = 1'b0;
      sel_pf     = 1'b0;
      drbank_req = '0;
      if (hold) begin
         sel_vld = 1'b1;
         sel_pf  = hold_pf;
      end else if ((starve_cnt == 4'(PF_STARVE)) && !p_empty) begin
         sel_vld = 1'b1;
         sel_pf  = 1'b1;
      end else if (!d_empty) begin
         sel_vld = 1'b1;
      end else if (!p_empty) begin
         sel_vld = 1'b1;
         sel_pf  = 1'b1;
      end
      if (sel_vld) begin
         drbank_req = sel_pf ? p_mem[p_rd_ptr] : d_mem[d_rd_ptr];
      end
   end

   // Payload storage; contents are don't-care until the matching pointer makes them valid
   always_ff @(posedge clk) begin
      if (d_push) d_mem[d_wr_ptr] <= l2todr_req;
      if (p_push) p_mem[p_wr_ptr] <= l2todr_pfreq;
   end

   // Demand queue pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_wr_ptr <= '0;
         d_rd_ptr <= '0;
         d_cnt    <= '0;
      end else begin
         if (d_push) d_wr_ptr <= d_wr_ptr + 1'b1;
         if (d_pop)  d_rd_ptr <= d_rd_ptr + 1'b1;
         case ({d_push, d_pop})
            2'b10:   d_cnt <= d_cnt + 1'b1;
            2'b01:   d_cnt <= d_cnt - 1'b1;
            default: d_cnt <= d_cnt;
         endcase
      end
   end

   // Prefetch queue pointers and occupancy; a drop advances the head and keeps the count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_wr_ptr <= '0;
         p_rd_ptr <= '0;
         p_cnt    <= '0;
      end else begin
         if (p_push)          p_wr_ptr <= p_wr_ptr + 1'b1;
         if (p_pop || p_drop) p_rd_ptr <= p_rd_ptr + 1'b1;
         case ({p_inc, p_pop})
            2'b10:   p_cnt <= p_cnt + 1'b1;
            2'b01:   p_cnt <= p_cnt - 1'b1;
            default: p_cnt <= p_cnt;
         endcase
      end
   end

   // Freeze the presented request while the bank refuses it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold    <= 1'b0;
         hold_pf <= 1'b0;
      end else if (sel_vld && drbank_req_retry) begin
         hold    <= 1'b1;
         hold_pf <= sel_pf;
      end else begin
         hold    <= 1'b0;
         hold_pf <= 1'b0;
      end
   end

   // Count demand grants that bypassed a waiting prefetch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (p_empty || p_pop) begin
         starve_cnt <= '0;
      end else if (d_pop && (starve_cnt != 4'(PF_STARVE))) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Saturating count of prefetches lost to overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_cnt <= '0;
      end else if (p_drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_directory_req_sched.sv
// Purpose: self-checking bench for directory_req_sched (REQ_DEPTH=8, PF_DEPTH=4, PF_STARVE=4).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled before the next edge.
// Backpressure: bank retry driven by the bench; scoreboard checks every bank transfer in order.
module tb_directory_req_sched;
   import directory_req_sched_pkg::*;

   typedef I_l2todr_req_type req_t;
   typedef struct packed {
      logic is_pf;
      req_t req;
   } exp_t;
   typedef struct {
      bit dv;
      int did;
      bit pv;
      int pid;
      bit ev;
      bit epf;
      int eid;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        d_vld = 1'b0, p_vld = 1'b0, bank_retry = 1'b0;
   req_t        d_dat = '0, p_dat = '0;
   logic        d_retry, p_retry, bank_vld, bank_is_pf;
   req_t        bank_dat;
   logic [15:0] drop_cnt;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   vec_t vt[15];

   directory_req_sched #(.REQ_DEPTH(8), .PF_DEPTH(4), .PF_STARVE(4)) dut (
      .clk                (clk),
      .reset              (rst_n),
      .l2todr_req_valid   (d_vld),
      .l2todr_req_retry   (d_retry),
      .l2todr_req         (d_dat),
      .l2todr_pfreq_valid (p_vld),
      .l2todr_pfreq_retry (p_retry),
      .l2todr_pfreq       (p_dat),
      .drbank_req_valid   (bank_vld),
      .drbank_req_retry   (bank_retry),
      .drbank_req         (bank_dat),
      .drbank_req_is_pf   (bank_is_pf),
      .pf_drop_cnt        (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic req_t mk(input int id);
      req_t r;
      r.nid   = 5'(id + 1);
      r.l2id  = 6'(id);
      r.cmd   = 3'(id);
      r.paddr = 38'(id * 64);
      return r;
   endfunction

   function automatic vec_t mkv(input bit dv, input int did, input bit pv, input int pid,
                                input bit ev, input bit epf, input int eid);
      vec_t v;
      v.dv = dv; v.did = did; v.pv = pv; v.pid = pid;
      v.ev = ev; v.epf = epf; v.eid = eid;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input bit is_pf, input int id);
      exp_t e;
      e.is_pf = is_pf;
      e.req   = mk(id);
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         cyc();
         if (!bank_vld && exp_q.size() == 0) done = 1'b1;
      end
      chk(name, 64'(done), 64'(1));
   endtask

   // Scoreboard: each bank transfer must match the oldest expected request
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && bank_vld && !bank_retry) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_xfer", 64'(bank_dat), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("sb_payload", 64'(bank_dat), 64'(e.req));
            chk("sb_is_pf", 64'(bank_is_pf), 64'(e.is_pf));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   got;
      int   k;
      // dv did pv pid | ev epf eid
      vt[0]  = mkv(1, 1, 0, 0, 0, 0, 0);
      vt[1]  = mkv(0, 0, 0, 0, 1, 0, 1);
      vt[2]  = mkv(0, 0, 0, 0, 0, 0, 0);
      vt[3]  = mkv(0, 0, 1, 2, 0, 0, 0);
      vt[4]  = mkv(1, 3, 0, 0, 1, 1, 2);
      vt[5]  = mkv(0, 0, 0, 0, 1, 0, 3);
      vt[6]  = mkv(1, 4, 1, 5, 0, 0, 0);
      vt[7]  = mkv(0, 0, 0, 0, 1, 0, 4);
      vt[8]  = mkv(0, 0, 0, 0, 1, 1, 5);
      vt[9]  = mkv(0, 0, 0, 0, 0, 0, 0);
      vt[10] = mkv(1, 6, 0, 0, 0, 0, 0);
      vt[11] = mkv(1, 7, 0, 0, 1, 0, 6);
      vt[12] = mkv(1, 8, 0, 0, 1, 0, 7);
      vt[13] = mkv(0, 0, 0, 0, 1, 0, 8);
      vt[14] = mkv(0, 0, 0, 0, 0, 0, 0);

      // Reset values
      #12;
      chk("rst_valid", 64'(bank_vld), 64'(0));
      chk("rst_is_pf", 64'(bank_is_pf), 64'(0));
      chk("rst_req", 64'(bank_dat), 64'(0));
      chk("rst_req_retry", 64'(d_retry), 64'(0));
      chk("rst_pf_retry", 64'(p_retry), 64'(0));
      chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // Cycle-by-cycle vectors: latency, arbitration basics, back-to-back
      for (int i = 0; i < 15; i++) begin
         d_vld = vt[i].dv; d_dat = mk(vt[i].did);
         p_vld = vt[i].pv; p_dat = mk(vt[i].pid);
         if (vt[i].dv) push_exp(1'b0, vt[i].did);
         if (vt[i].pv) push_exp(1'b1, vt[i].pid);
         #1;
         chk($sformatf("vec%0d_valid", i), 64'(bank_vld), 64'(vt[i].ev));
         if (vt[i].ev) begin
            chk($sformatf("vec%0d_is_pf", i), 64'(bank_is_pf), 64'(vt[i].epf));
            chk($sformatf("vec%0d_req", i), 64'(bank_dat), 64'(mk(vt[i].eid)));
         end
         chk($sformatf("vec%0d_req_retry", i), 64'(d_retry), 64'(0));
         chk($sformatf("vec%0d_pf_retry", i), 64'(p_retry), 64'(0));
         cyc();
      end
      d_vld = 1'b0; p_vld = 1'b0;
      wait_drain("vec_drain");

      // Demand queue fill: 8 accepted, 9th only after a bank transfer
      bank_retry = 1'b1;
      for (int i = 0; i < 9; i++) begin
         d_vld = 1'b1; d_dat = mk(20 + i);
         #1;
         chk($sformatf("fill%0d_retry", i), 64'(d_retry), 64'(i == 8));
         if (!d_retry) push_exp(1'b0, 20 + i);
         cyc();
      end
      bank_retry = 1'b0;
      #1;
      chk("full_pop_refuses_push", 64'(d_retry), 64'(1));
      cyc();
      bank_retry = 1'b1;
      #1;
      chk("retry_after_pop", 64'(d_retry), 64'(0));
      if (!d_retry) push_exp(1'b0, 28);
      cyc();
      d_vld = 1'b0;
      #1;
      chk("full_again", 64'(d_retry), 64'(1));
      bank_retry = 1'b0;
      wait_drain("fill_drain");

      // Prefetch overflow drops the oldest while a demand is held
      bank_retry = 1'b1;
      d_vld = 1'b1; d_dat = mk(30); push_exp(1'b0, 30);
      cyc();
      d_vld = 1'b0;
      for (int i = 0; i < 6; i++) begin
         p_vld = 1'b1; p_dat = mk(40 + i);
         #1;
         chk($sformatf("drop%0d_pf_retry", i), 64'(p_retry), 64'(0));
         cyc();
      end
      p_vld = 1'b0;
      #1;
      chk("drop_cnt_2", 64'(drop_cnt), 64'(2));
      chk("drop_demand_held", 64'(bank_dat), 64'(mk(30)));
      for (int i = 2; i < 6; i++) push_exp(1'b1, 40 + i);
      bank_retry = 1'b0;
      wait_drain("drop_drain");

      // Starvation guard: four demand grants, then the pending prefetch
      bank_retry = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d_vld = 1'b1; d_dat = mk(50 + i);
         cyc();
      end
      d_vld = 1'b0;
      p_vld = 1'b1; p_dat = mk(60);
      #1;
      chk("starve_demand_full", 64'(d_retry), 64'(1));
      cyc();
      p_vld = 1'b0;
      for (int i = 0; i < 4; i++) push_exp(1'b0, 50 + i);
      push_exp(1'b1, 60);
      for (int i = 4; i < 8; i++) push_exp(1'b0, 50 + i);
      bank_retry = 1'b0;
      k = 0;
      for (int c = 0; c < 40 && k < 2; c++) begin
         d_vld = 1'b1; d_dat = mk(58 + k);
         #1;
         if (!d_retry) begin
            push_exp(1'b0, 58 + k);
            k++;
         end
         cyc();
      end
      d_vld = 1'b0;
      chk("starve_late_pushes", 64'(k), 64'(2));
      wait_drain("starve_drain");

      // Held prefetch with full queue: prefetch port retries, no drop, no displacement
      bank_retry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         p_vld = 1'b1; p_dat = mk(70 + i);
         cyc();
      end
      p_vld = 1'b1; p_dat = mk(74);
      d_vld = 1'b1; d_dat = mk(75);
      #1;
      chk("held_pf_retry", 64'(p_retry), 64'(1));
      chk("held_pf_is_pf", 64'(bank_is_pf), 64'(1));
      cyc();
      d_vld = 1'b0;
      #1;
      chk("held_pf_retry2", 64'(p_retry), 64'(1));
      chk("held_pf_is_pf2", 64'(bank_is_pf), 64'(1));
      chk("held_pf_payload", 64'(bank_dat), 64'(mk(70)));
      chk("held_pf_no_drop", 64'(drop_cnt), 64'(2));
      push_exp(1'b1, 70);
      push_exp(1'b0, 75);
      for (int i = 1; i < 4; i++) push_exp(1'b1, 70 + i);
      bank_retry = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         #1;
         if (!p_retry) begin
            push_exp(1'b1, 74);
            got = 1'b1;
         end
         cyc();
      end
      p_vld = 1'b0;
      chk("held_pf_late_push", 64'(got), 64'(1));
      wait_drain("held_drain");

      // Asynchronous reset with both queues loaded and a request held
      bank_retry = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d_vld = 1'b1; d_dat = mk(80 + i);
         cyc();
      end
      d_vld = 1'b0;
      for (int i = 0; i < 2; i++) begin
         p_vld = 1'b1; p_dat = mk(83 + i);
         cyc();
      end
      p_vld = 1'b0;
      #1;
      chk("pre_rst_held", 64'(bank_vld), 64'(1));
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_valid", 64'(bank_vld), 64'(0));
      chk("arst_is_pf", 64'(bank_is_pf), 64'(0));
      chk("arst_req", 64'(bank_dat), 64'(0));
      chk("arst_req_retry", 64'(d_retry), 64'(0));
      chk("arst_pf_retry", 64'(p_retry), 64'(0));
      chk("arst_drop_cnt", 64'(drop_cnt), 64'(0));
      bank_retry = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      d_vld = 1'b1; d_dat = mk(90); push_exp(1'b0, 90);
      #1;
      chk("post_rst_no_bypass", 64'(bank_vld), 64'(0));
      cyc();
      d_vld = 1'b0;
      #1;
      chk("post_rst_valid", 64'(bank_vld), 64'(1));
      chk("post_rst_req", 64'(bank_dat), 64'(mk(90)));
      cyc();
      #1;
      chk("post_rst_idle", 64'(bank_vld), 64'(0));
      chk("sb_empty", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
